mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N, default 4, operand width of the shared shift-add multiplier.
REQ-002 Parameter TMO, default 32, WAIT-state timeout in clock cycles (TMO >= 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req  input  4  per-requester request, level, bit i = requester i.
REQ-006 a_in  input  4N  operand A; requester i occupies bits [iN+N-1:iN].
REQ-007 b_in  input  4N  operand B; same packing as a_in.
REQ-008 gnt  output  4  one-hot grant, registered.
REQ-009 done  output  4  one-cycle completion pulse to the granted requester.
REQ-010 err  output  1  qualifies done; 1 = timeout, result invalid.
REQ-011 result  output  2N  product returned to the requester; valid while done != 0.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-014 mul_a  output  N  latched operand A to the multiplier.
REQ-015 mul_b  output  N  latched operand B to the multiplier.
REQ-016 mul_out  input  2N  multiplier product.
REQ-017 mul_valid  input  1  multiplier completion flag; sampled only in WAIT.

Function
REQ-018 The FSM shall have states IDLE, ISSUE, WAIT, DONE.
REQ-019 In IDLE with req != 0, the block shall select one requester by round-robin from pointer ptr, latch its operands into mul_a/mul_b, set gnt to that one-hot bit, and go to ISSUE.
REQ-020 Round-robin: search order ptr, ptr+1, ... ptr+3 (mod 4); first set req bit wins.
REQ-021 In IDLE with req == 0, the block shall stay in IDLE with gnt = 0.
REQ-022 ISSUE shall last exactly one cycle with mul_start = 1, then go to WAIT.
REQ-023 mul_start shall be 0 in every state other than ISSUE.
REQ-024 In WAIT the block shall count cycles from 1.
REQ-025 On mul_valid = 1 in WAIT, the block shall register mul_out into result, set err = 0, and go to DONE.
REQ-026 If the count reaches TMO without mul_valid, the block shall set result = 0 and err = 1, and go to DONE.
REQ-027 If mul_valid and the timeout occur in the same cycle, mul_valid shall take precedence.
REQ-028 DONE shall last one cycle: done = gnt and err holds its value.
REQ-029 On leaving DONE, ptr shall become granted index + 1 (mod 4), gnt shall clear, and the FSM shall return to IDLE.
REQ-030 Minimum grant-to-grant spacing is IDLE + ISSUE + WAIT + DONE; no back-to-back issue without passing IDLE.
REQ-031 gnt shall stay constant from the ISSUE entry through DONE inclusive.
REQ-032 mul_a/mul_b shall stay constant from latch through DONE; operand changes on a_in/b_in after grant shall be ignored.
REQ-033 Deasserting the granted req bit after grant shall not abort the transaction; done still pulses.
REQ-034 mul_valid outside WAIT shall be ignored.
REQ-035 result shall hold its last value outside DONE.
REQ-036 done and err shall be 0 outside DONE.
REQ-037 Arithmetic is unsigned; result is exactly 2N bits, with no truncation or extension.

Reset
REQ-038 While rst_n = 0 at a clock edge, the block shall enter IDLE with ptr = 0, gnt = 0, done = 0, err = 0, result = 0, busy = 0, mul_start = 0, mul_a = 0, mul_b = 0, and the WAIT count = 0.
REQ-039 Reset asserted mid-transaction (any state) shall abandon the transaction with no done pulse.
REQ-040 The first grant after reset shall follow the round-robin order from ptr = 0.

Verification
REQ-041 Single request: req = 0001, A0 = 3, B0 = 5, multiplier returns after 4 cycles -> mul_start pulses once, done = 0001, result = 15, err = 0.
REQ-042 All requesting: req = 1111 held, operands (i+1, 2) for requester i -> grant order 0, 1, 2, 3, 0, with results 2, 4, 6, 8.
REQ-043 Fairness: req = 0101 held -> grants alternate 0001, 0100, 0001; each requester is served with no starvation.
REQ-044 Timeout: mul_valid tied to 0, TMO = 32 -> done pulses 32 cycles after WAIT entry, with err = 1 and result = 0; the next grant goes to the following requester.
REQ-045 Max operands: A = B = 15 -> result = 225 (8'hE1).
REQ-046 Reset in WAIT: rst_n = 0 for one cycle during WAIT -> no done pulse; all outputs return to reset values; ptr = 0.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Bus bundle between the four-requester arbiter and its shared multiplier.
// slave = arbiter view, master = requester/multiplier side.
interface mul_arbiter_if #(
  parameter int N = 4
);
  logic [3:0]     req;
  logic [4*N-1:0] a_in;
  logic [4*N-1:0] b_in;
  logic [3:0]     gnt;
  logic [3:0]     done;
  logic           err;
  logic [2*N-1:0] result;
  logic           busy;
  logic           mul_start;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] mul_out;
  logic           mul_valid;

  modport slave (
    input  req, a_in, b_in, mul_out, mul_valid,
    output gnt, done, err, result, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req, a_in, b_in, mul_out, mul_valid,
    input  gnt, done, err, result, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter granting four requesters access to one shift-add
// multiplier, with a WAIT-state timeout that returns err instead of a product.
module mul_arbiter #(
  parameter int N   = 4,
  parameter int TMO = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     gnt_q, gnt_d;
  logic           err_q, err_d;
  logic [2*N-1:0] result_q, result_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           sel_found;
  logic [1:0]     sel_idx;
  logic [1:0]     cand;

  // First set request bit at or after ptr, wrapping modulo 4.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    err_d    = err_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          gnt_d   = 4'(1) << sel_idx;
          a_d     = bus.a_in[int'(sel_idx)*N +: N];
          b_d     = bus.b_in[int'(sel_idx)*N +: N];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A product arriving on the timeout cycle still wins.
        if (bus.mul_valid) begin
          result_d = bus.mul_out;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == CW'(TMO)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        ptr_d   = idx_q + 2'd1;
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = (state_q == S_DONE) ? gnt_q : '0;
  assign bus.err       = (state_q == S_DONE) & err_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mul_start = (state_q == S_ISSUE);
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural multiplier with programmable latency,
// table of transactions plus hand sequences for reset and operand changes.
module tb_mul_arbiter;

  localparam int N   = 4;
  localparam int TMO = 32;
  localparam int W   = 2 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if #(.N(N)) bus ();

  mul_arbiter #(.N(N), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]     req;
    logic [4*N-1:0] a;
    logic [4*N-1:0] b;
    int             lat;
    logic [3:0]     gnt;
    logic [W-1:0]   res;
    logic           err;
  } vec_t;

  typedef struct {
    logic [3:0]   gnt;
    logic [W-1:0] res;
    logic         err;
    int           dly;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[13];

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_start = 0;
  int n_start_exp = 0;
  int cyc = 0;
  int t_issue = 0;

  // Multiplier model: lat cycles after the start edge it raises mul_valid for
  // one cycle; lat = 0 never answers.
  int           m_lat = 0;
  int           cd;
  logic         mv;
  logic [W-1:0] mo;
  logic [W-1:0] prod;

  assign bus.mul_valid = mv;
  assign bus.mul_out   = mo;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      cd   <= 0;
      mv   <= 1'b0;
      mo   <= '0;
      prod <= '0;
    end else begin
      mv <= 1'b0;
      if (bus.mul_start) begin
        cd   <= m_lat;
        prod <= W'(bus.mul_a) * W'(bus.mul_b);
      end else if (cd == 1) begin
        mv <= 1'b1;
        mo <= prod;
        cd <= 0;
      end else if (cd > 1) begin
        cd <= cd - 1;
      end
    end
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.mul_start) begin
        t_issue = cyc;
        n_start++;
      end
      if (bus.done != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("done", 32'(bus.done), 32'(e.gnt));
          check("gnt_at_done", 32'(bus.gnt), 32'(e.gnt));
          check("result", 32'(bus.result), 32'(e.res));
          check("err", 32'(bus.err), 32'(e.err));
          check("latency", 32'(cyc - t_issue), 32'(e.dly));
        end
        n_done++;
      end else begin
        check("err_outside_done", 32'(bus.err), 32'(0));
      end
    end
  end

  task automatic run_txn(input logic [3:0] req, input logic [4*N-1:0] a, input logic [4*N-1:0] b,
                         input int lat, input logic [3:0] g, input logic [W-1:0] r, input logic e,
                         input bit scramble);
    exp_t x;
    int   target;
    int   starts;
    bit   ok;
    x.gnt = g;
    x.res = r;
    x.err = e;
    x.dly = (lat == 0 || lat >= TMO) ? TMO + 1 : lat + 2;
    sb_q.push_back(x);
    n_start_exp++;
    target = n_done + 1;
    starts = n_start;
    m_lat = lat;
    bus.req = req;
    bus.a_in = a;
    bus.b_in = b;
    if (scramble) begin
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        #1;
        if (n_start > starts) ok = 1'b1;
      end
      check("scramble_start_seen", 32'(ok), 32'(1));
      bus.req = '0;
      bus.a_in = '1;
      bus.b_in = '1;
    end
    ok = 1'b0;
    for (int c = 0; c < TMO + 50 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (n_done >= target) ok = 1'b1;
    end
    check("txn_complete", 32'(ok), 32'(1));
    if (!ok) sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(0));
    check({tag, "_done"}, 32'(bus.done), 32'(0));
    check({tag, "_err"}, 32'(bus.err), 32'(0));
    check({tag, "_result"}, 32'(bus.result), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_mul_start"}, 32'(bus.mul_start), 32'(0));
    check({tag, "_mul_a"}, 32'(bus.mul_a), 32'(0));
    check({tag, "_mul_b"}, 32'(bus.mul_b), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    bit ok;

    tbl[0]  = '{4'b1111, 16'h4321, 16'h2222, 1,  4'b0001, 8'd2,   1'b0};
    tbl[1]  = '{4'b1111, 16'h4321, 16'h2222, 2,  4'b0010, 8'd4,   1'b0};
    tbl[2]  = '{4'b1111, 16'h4321, 16'h2222, 3,  4'b0100, 8'd6,   1'b0};
    tbl[3]  = '{4'b1111, 16'h4321, 16'h2222, 4,  4'b1000, 8'd8,   1'b0};
    tbl[4]  = '{4'b1111, 16'h4321, 16'h2222, 5,  4'b0001, 8'd2,   1'b0};
    tbl[5]  = '{4'b0101, 16'h0503, 16'h0704, 2,  4'b0100, 8'd35,  1'b0};
    tbl[6]  = '{4'b0101, 16'h0503, 16'h0704, 3,  4'b0001, 8'd12,  1'b0};
    tbl[7]  = '{4'b0101, 16'h0503, 16'h0704, 1,  4'b0100, 8'd35,  1'b0};
    tbl[8]  = '{4'b1000, 16'hF000, 16'hF000, 4,  4'b1000, 8'hE1,  1'b0};
    tbl[9]  = '{4'b0010, 16'h0090, 16'h0090, 0,  4'b0010, 8'd0,   1'b1};
    tbl[10] = '{4'b0110, 16'h0A90, 16'h0C90, 2,  4'b0100, 8'd120, 1'b0};
    tbl[11] = '{4'b0001, 16'h000D, 16'h000B, 31, 4'b0001, 8'd143, 1'b0};
    tbl[12] = '{4'b0001, 16'h0002, 16'h0002, 32, 4'b0001, 8'd0,   1'b1};

    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle with no requests: nothing is granted.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_gnt", 32'(bus.gnt), 32'(0));
      check("idle_busy", 32'(bus.busy), 32'(0));
    end

    run_txn(4'b0001, 16'h0003, 16'h0005, 4, 4'b0001, 8'd15, 1'b0, 1'b0);

    // Reset while in WAIT: transaction dropped, no done, all outputs cleared.
    n_start_exp++;
    starts  = n_start;
    m_lat   = 0;
    bus.req = 4'b0100;
    bus.a_in = 16'h0300;
    bus.b_in = 16'h0300;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      #1;
      if (n_start > starts) ok = 1'b1;
    end
    check("rst_seq_start_seen", 32'(ok), 32'(1));
    repeat (4) @(negedge clk);
    #1;
    check("rst_seq_in_wait_busy", 32'(bus.busy), 32'(1));
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_wait");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_gnt", 32'(bus.gnt), 32'(0));
      check("post_rst_done", 32'(bus.done), 32'(0));
    end

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].gnt, tbl[i].res, tbl[i].err, 1'b0);
    end

    // Request withdrawn and operands changed right after grant.
    run_txn(4'b0010, 16'h0070, 16'h0060, 3, 4'b0010, 8'd42, 1'b0, 1'b1);

    bus.req = '0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("final_idle_gnt", 32'(bus.gnt), 32'(0));
      check("final_idle_busy", 32'(bus.busy), 32'(0));
    end

    check("mul_start_count", 32'(n_start), 32'(n_start_exp));
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
